// File: rtl/uram_burst_port.sv
// Burst sequencer for one URAM port: expands a command into 1..2^(2^CLASS_BITS-1) word accesses.
// Latency: mem_* registered 1 cycle after accept/beat; read data reaches rd_* RD_LAT+2 cycles after issue.
// Backpressure: reads issue only against free FIFO credits, so rd_ready low never drops or overwrites a beat.
module uram_burst_port #(
  parameter int DATA_W     = 528,
  parameter int MEM_W      = 576,
  parameter int ADDR_W     = 16,
  parameter int CLASS_BITS = 2,
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = RD_LAT + 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic                  cmd_wr,
  input  logic                  wr_valid,
  input  logic [DATA_W-1:0]     wr_data,
  output logic                  wr_ready,
  output logic                  rd_valid,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  rd_last,
  input  logic                  rd_ready,
  output logic                  mem_en,
  output logic                  mem_wr,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [MEM_W-1:0]      mem_wdata,
  output logic [MEM_W/64-1:0]   mem_bwe,
  input  logic [MEM_W-1:0]      mem_rdata,
  output logic                  busy
);

  localparam int LOW_W  = ADDR_W - CLASS_BITS;
  // Largest burst is 2^(2^CLASS_BITS-1) beats, which needs 2^CLASS_BITS bits to hold.
  localparam int BEAT_W = 1 << CLASS_BITS;
  localparam int BWE_W  = MEM_W / 64;
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int CW     = CNT_W + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  state_t r_state, w_next;

  logic [CLASS_BITS-1:0] r_class;
  logic [LOW_W-1:0]      r_base_low;
  logic [BEAT_W-1:0]     r_beats;
  logic [BEAT_W-1:0]     r_idx;

  logic                  r_mem_en;
  logic                  r_mem_wr;
  logic                  r_mem_last;
  logic [ADDR_W-1:0]     r_mem_addr;
  logic [MEM_W-1:0]      r_mem_wdata;
  logic [BWE_W-1:0]      r_mem_bwe;

  logic [RD_LAT-1:0]     r_pipe_vld;
  logic [RD_LAT-1:0]     r_pipe_last;

  logic [CNT_W-1:0]      r_inflight;
  logic [CNT_W-1:0]      r_count;
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [DATA_W-1:0]     r_fifo_dat  [FIFO_DEPTH];
  logic                  r_fifo_last [FIFO_DEPTH];

  logic                  w_accept;
  logic                  w_issue;
  logic                  w_wr_beat;
  logic                  w_last_beat;
  logic                  w_credit_ok;
  logic                  w_push;
  logic                  w_pop;
  logic [CLASS_BITS-1:0] w_cmd_class;
  logic [BEAT_W-1:0]     w_cmd_beats;
  logic [ADDR_W-1:0]     w_addr;
  logic [CW-1:0]         w_used;
  logic [CW-1:0]         w_limit;
  logic                  w_unused_rdata;

  assign w_cmd_class = cmd_addr[ADDR_W-1 -: CLASS_BITS];
  assign w_cmd_beats = BEAT_W'(1) << w_cmd_class;
  // The burst stays inside its class region: only the low field advances and wraps.
  assign w_addr      = {r_class, r_base_low + LOW_W'(r_idx)};
  assign w_last_beat = (r_idx == r_beats - 1'b1);

  // Credits: a pop this cycle frees its slot for an issue in the same cycle.
  assign w_pop       = (r_count != '0) && rd_ready;
  assign w_push      = r_pipe_vld[RD_LAT-1];
  assign w_used      = CW'(r_count) + CW'(r_inflight);
  assign w_limit     = CW'(FIFO_DEPTH) + CW'(w_pop);
  assign w_credit_ok = (w_used < w_limit);

  // Next state and handshake decodes for the serial command FSM.
  always_comb begin
    w_next    = r_state;
    cmd_ready = 1'b0;
    wr_ready  = 1'b0;
    w_accept  = 1'b0;
    w_issue   = 1'b0;
    w_wr_beat = 1'b0;
    case (r_state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          w_accept = 1'b1;
          w_next   = cmd_wr ? S_WRITE : S_READ;
        end
      end
      S_READ: begin
        if ((r_idx < r_beats) && w_credit_ok) begin
          w_issue = 1'b1;
          if (w_last_beat) w_next = S_IDLE;
        end
      end
      S_WRITE: begin
        wr_ready = 1'b1;
        if (wr_valid) begin
          w_wr_beat = 1'b1;
          if (w_last_beat) w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Command latch, beat index and registered memory request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_class     <= '0;
      r_base_low  <= '0;
      r_beats     <= '0;
      r_idx       <= '0;
      r_mem_en    <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_mem_last  <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_bwe   <= '0;
    end else begin
      r_mem_en <= w_issue | w_wr_beat;
      if (w_accept) begin
        r_class    <= w_cmd_class;
        r_base_low <= cmd_addr[LOW_W-1:0];
        r_beats    <= w_cmd_beats;
        r_idx      <= '0;
      end
      if (w_issue) begin
        r_mem_wr   <= 1'b0;
        r_mem_addr <= w_addr;
        r_mem_bwe  <= '0;
        r_mem_last <= w_last_beat;
        r_idx      <= r_idx + 1'b1;
      end
      if (w_wr_beat) begin
        r_mem_wr    <= 1'b1;
        r_mem_addr  <= w_addr;
        r_mem_wdata <= MEM_W'(wr_data);
        r_mem_bwe   <= '1;
        r_mem_last  <= 1'b0;
        r_idx       <= r_idx + 1'b1;
      end
    end
  end

  // Valid/last shift pipe matching the memory read latency; reset discards in-flight reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pipe_vld  <= '0;
      r_pipe_last <= '0;
    end else begin
      r_pipe_vld[0]  <= r_mem_en & ~r_mem_wr;
      r_pipe_last[0] <= r_mem_last;
      for (int i = 1; i < RD_LAT; i++) begin
        r_pipe_vld[i]  <= r_pipe_vld[i-1];
        r_pipe_last[i] <= r_pipe_last[i-1];
      end
    end
  end

  // In-flight read counter and FIFO pointers/occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inflight <= '0;
      r_count    <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
    end else begin
      case ({w_issue, w_push})
        2'b10:   r_inflight <= r_inflight + 1'b1;
        2'b01:   r_inflight <= r_inflight - 1'b1;
        default: r_inflight <= r_inflight;
      endcase
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_push) r_wr_ptr <= (r_wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= (r_rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
    end
  end

  // FIFO storage; contents are only observed while occupied, so no reset is needed.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_dat[r_wr_ptr]  <= mem_rdata[DATA_W-1:0];
      r_fifo_last[r_wr_ptr] <= r_pipe_last[RD_LAT-1];
    end
  end

  assign rd_valid  = (r_count != '0);
  assign rd_data   = rd_valid ? r_fifo_dat[r_rd_ptr] : '0;
  assign rd_last   = rd_valid & r_fifo_last[r_rd_ptr];

  assign mem_en    = r_mem_en;
  assign mem_wr    = r_mem_wr;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_bwe   = r_mem_bwe;

  assign busy      = (r_state != S_IDLE) || (r_count != '0) || (r_inflight != '0);

  // Bits of the memory word above DATA_W carry nothing for the packet stream.
  assign w_unused_rdata = ^mem_rdata;

endmodule

// File: doc/uram_burst_port.md
Name: uram_burst_port

Overview:
- Generalised single-port burst sequencer for the UDP shell packet buffer; one instance per URAM port, so the dual-port top instantiates two.
- Accepts a command (address and read/write), then expands it into 1..MAX_BEATS consecutive memory words using the size-class field in the address MSBs.
- The read return path is fully backpressure-safe. A credit-tracked output FIFO absorbs the memory read latency, so no read beat is ever dropped or overwritten while rd_ready is low.
- Width, depth, class count and memory latency are parameters.

Parameters:
DATA_W, 528, payload width on wr/rd streams
MEM_W, 576, memory word width; DATA_W <= MEM_W, MEM_W multiple of 64
ADDR_W, 16, memory word address width
CLASS_BITS, 2, number of address MSBs holding size class; beats = 1 << class
RD_LAT, 1, cycles from registered mem_en (read) to valid mem_rdata; >= 1
FIFO_DEPTH, RD_LAT+2, output FIFO entries; >= RD_LAT+1

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command valid
cmd_ready  out  1  command accepted when valid&&ready
cmd_addr  in  ADDR_W  base address; [ADDR_W-1 -: CLASS_BITS] = class
cmd_wr  in  1  1 write, 0 read
wr_valid  in  1  write beat valid
wr_data  in  DATA_W  write beat
wr_ready  out  1  write beat accepted
rd_valid  out  1  read beat valid
rd_data  out  DATA_W  read beat
rd_last  out  1  final beat of a read burst
rd_ready  in  1  downstream ready
mem_en  out  1  memory enable
mem_wr  out  1  1 write, 0 read
mem_addr  out  ADDR_W  memory address
mem_wdata  out  MEM_W  {zeros, wr_data}
mem_bwe  out  MEM_W/64  byte-lane-group enables; all ones on every write
mem_rdata  in  MEM_W  read data
busy  out  1  state != IDLE or FIFO non-empty or reads in flight

Behaviour:
- Reset values: all outputs 0 except cmd_ready=1.
  - State goes to IDLE; counters, credits and FIFO pointers clear.
  - A reset mid-burst aborts the burst; in-flight reads are discarded and never appear on rd_*.
- States: IDLE, READ, WRITE.
- IDLE: cmd_ready=1.
  - On acceptance, latch base, class and beats=1<<class, and clear the beat index. Go to READ if cmd_wr=0, else WRITE.
  - cmd_ready drops the next cycle.
- Address generation: mem_addr = {class, (base_low + idx) mod 2^(ADDR_W-CLASS_BITS)}.
  - The burst wraps inside its class region and never changes class.
- WRITE: wr_ready=1.
  - Each wr_valid&&wr_ready registers mem_en=1, mem_wr=1, mem_addr, mem_wdata and mem_bwe for one cycle, then increments idx.
  - After the beat where idx+1==beats, return to IDLE.
  - wr_* is ignored outside WRITE (wr_ready=0).
- READ: issue one read per cycle (mem_en=1, mem_wr=0) while idx<beats AND credits>0.
  - credits = FIFO_DEPTH − FIFO occupancy − reads in flight.
  - Each issue tags rd_last for idx==beats−1.
  - A RD_LAT-deep valid/last shift pipe writes mem_rdata[DATA_W-1:0] and the tag into the FIFO.
  - Go to IDLE the cycle after the last issue. A new command may be accepted while the FIFO still drains.
- FIFO output: rd_valid = non-empty; pop on rd_valid&&rd_ready.
  - Simultaneous push and pop leaves occupancy unchanged; pop frees a credit in the same cycle.
  - Overflow is impossible by construction; the bench asserts it.
- Ordering: a write accepted after a read command never reaches memory before all of that read's issues. This is guaranteed by the serial FSM.
- Beat count: 1..2^(2^CLASS_BITS−1); counters are sized to hold beats.

Test Plan:
- Class-0 write: addr 0x0010, data A5.. -> one mem write cycle at 0x0010, mem_bwe all ones, upper 48 bits zero; IDLE the next cycle.
- Class-3 write then read: addr 0xC000, 8 beats D0..D7 -> mem writes at 0xC000..0xC007. Read returns D0..D7 in order with rd_last only on D7.
- Backpressure: class-2 read with rd_ready held 0 for 20 cycles -> at most FIFO_DEPTH issues, no loss. Releasing rd_ready delivers 4 beats contiguously.
- Region wrap: class-1 read at 0x7FFF -> reads at 0x7FFF then 0x4000.
- Back-to-back: read class 2 then immediate read class 0 -> cmd accepted while FIFO drains, 5 beats total, rd_last on beats 4 and 5.
- Reset mid-read (RD_LAT=3, 2 reads in flight) -> rd_valid=0, cmd_ready=1, busy=0 after reset; no stale beats later.
